mult_mac_pipe: RTL and testbench

- Multi-lane, pipelined signed fixed-point multiplier / multiply-accumulate unit for the CNN datapath.
- Generalises the single combinational Q-format multiplier with:
  - LANES parallel lanes
  - selectable truncate/round modes
  - per-lane accumulation for dot-product packets
  - output saturation with sticky overflow flags
  - valid/ready handshaking on both sides
- Sits between the feature/weight buffers and the activation stage.

---
 rtl/mult_mac_pkg.sv | 13 +
 rtl/mult_mac_lane.sv | 51 +++++
 rtl/mult_mac_pipe.sv | 82 ++++++++
 tb/tb_mult_mac_pipe.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_mac_pkg.sv
// mult_mac_pkg: shared modes, default widths and saturation helper for the MAC pipeline
package mult_mac_pkg;
  typedef enum logic [1:0] {MODE_TRUNC = 2'd0, MODE_RND = 2'd1, MODE_MAC = 2'd2} mode_t;
  localparam int DATA_WID_D = 16;
  localparam int AUG_FCT_B_D = 7;
  localparam int ACC_WID_D = 40;
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return v > hi ? hi : (v < lo ? lo : v);
  endfunction
endpackage

// File: rtl/mult_mac_lane.sv
// mult_mac_lane: one lane's product, accumulate, round, shift and saturate stages
module mult_mac_lane
  import mult_mac_pkg::*;
#(
  parameter int DATA_WID  = DATA_WID_D,
  parameter int AUG_FCT_B = AUG_FCT_B_D,
  parameter int ACC_WID   = ACC_WID_D
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ld,
  input  logic                       step,
  input  logic                       ovf_clr,
  input  logic signed [DATA_WID-1:0] a,
  input  logic signed [DATA_WID-1:0] b,
  input  mode_t                      mode,
  input  logic                       first,
  input  logic                       last,
  output logic [DATA_WID-1:0]        res,
  output logic                       ovf
);
  localparam logic signed [ACC_WID-1:0] HALF = ACC_WID'(1) << (AUG_FCT_B - 1);
  logic signed [2*DATA_WID-1:0] prod;
  logic signed [ACC_WID-1:0] acc, p_ext, acc_sum, pre, shifted;
  logic signed [63:0] sat;
  logic is_mac, emit, hit;
  // S3 arithmetic: MAC sums into the accumulator, other modes shift the bare product
  always_comb begin
    p_ext = ACC_WID'(prod);
    is_mac = mode == MODE_MAC;
    emit = !is_mac || last;
    acc_sum = (first ? '0 : acc) + p_ext;
    pre = is_mac ? acc_sum : (mode == MODE_RND ? p_ext + HALF : p_ext);
    shifted = pre >>> AUG_FCT_B;
    sat = saturate(64'(shifted), DATA_WID);
    hit = sat != 64'(shifted);
  end
  // S2 product register, S3 accumulator/result register and sticky overflow
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prod <= '0;
      acc <= '0;
      res <= '0;
      ovf <= 1'b0;
    end else begin
      if (ld) prod <= (2*DATA_WID)'(a) * (2*DATA_WID)'(b);
      if (step) acc <= is_mac ? acc_sum : '0;
      if (step && emit) res <= sat[DATA_WID-1:0];
      ovf <= !ovf_clr && (ovf || (step && emit && hit));
    end
endmodule

// File: rtl/mult_mac_pipe.sv
// mult_mac_pipe: multi-lane 3-stage Q-format multiplier / MAC with valid/ready handshake
module mult_mac_pipe
  import mult_mac_pkg::*;
#(
  parameter int DATA_WID  = DATA_WID_D,
  parameter int AUG_FCT_B = AUG_FCT_B_D,
  parameter int LANES     = 4,
  parameter int ACC_WID   = ACC_WID_D
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_WID-1:0] in_a,
  input  logic [LANES*DATA_WID-1:0] in_b,
  input  logic [1:0]                in_mode,
  input  logic                      in_first,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_WID-1:0] out_data,
  output logic [LANES-1:0]          out_ovf,
  input  logic                      ovf_clr
);
  logic en, adv1, adv2, v1, v2, first1, last1, first2, last2;
  mode_t mode1, mode2;
  logic [LANES*DATA_WID-1:0] a1, b1;
  assign en = !out_valid || out_ready;
  assign adv2 = en || !v2;
  assign adv1 = adv2 || !v1;
  assign in_ready = en;
  // S1: capture operands and control; the reserved mode folds into truncate
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1 <= 1'b0;
      a1 <= '0;
      b1 <= '0;
      mode1 <= MODE_TRUNC;
      first1 <= 1'b0;
      last1 <= 1'b0;
    end else if (adv1) begin
      v1 <= in_valid && en;
      a1 <= in_a;
      b1 <= in_b;
      mode1 <= in_mode == 2'd1 ? MODE_RND : (in_mode == 2'd2 ? MODE_MAC : MODE_TRUNC);
      first1 <= in_first;
      last1 <= in_last;
    end
  // S2 control, moving alongside the lane product registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v2 <= 1'b0;
      mode2 <= MODE_TRUNC;
      first2 <= 1'b0;
      last2 <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      mode2 <= mode1;
      first2 <= first1;
      last2 <= last1;
    end
  // S3 output valid: MAC beats only surface on the packet's last beat
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) out_valid <= 1'b0;
    else if (en) out_valid <= v2 && (mode2 != MODE_MAC || last2);
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mult_mac_lane #(.DATA_WID(DATA_WID), .AUG_FCT_B(AUG_FCT_B), .ACC_WID(ACC_WID)) u_lane (
      .clk(clk),
      .rst_n(rst_n),
      .ld(adv2),
      .step(en && v2),
      .ovf_clr(ovf_clr),
      .a(a1[i*DATA_WID +: DATA_WID]),
      .b(b1[i*DATA_WID +: DATA_WID]),
      .mode(mode2),
      .first(first2),
      .last(last2),
      .res(out_data[i*DATA_WID +: DATA_WID]),
      .ovf(out_ovf[i])
    );
  end
endmodule

// File: tb/tb_mult_mac_pipe.sv
// tb_mult_mac_pipe: scoreboard bench with a plain-arithmetic reference model
module tb_mult_mac_pipe;
  localparam int W = 16, L = 4, F = 7;
  logic clk = 0, rst_n = 0, in_valid = 0, in_first = 0, in_last = 0, out_ready = 1, ovf_clr = 0;
  logic [1:0] in_mode = 0;
  logic [L*W-1:0] in_a = 0, in_b = 0, out_data;
  logic in_ready, out_valid;
  logic [L-1:0] out_ovf;

  always #5 clk = ~clk;

  mult_mac_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_mode(in_mode), .in_first(in_first), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf), .ovf_clr(ovf_clr)
  );

  typedef struct {logic [L*W-1:0] data; logic [L-1:0] ovf; int t; int st;} exp_t;
  exp_t sb[$];
  longint acc_m[L];
  logic [L-1:0] ovf_m = '0;
  bit clr_next = 0, holding = 0, saw_full = 0, done = 0;
  int checks = 0, errors = 0, cyc = 0, stalls = 0, n_out = 0, n0;
  logic [L*W-1:0] last_out = '0, held = '0;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: per-lane integer arithmetic straight from the mode rules
  task automatic model(logic [1:0] m, logic [L*W-1:0] a, logic [L*W-1:0] b, bit f, bit l);
    exp_t e;
    bit emit;
    longint p, r, hi, lo;
    e.data = '0;
    emit = 1;
    hi = (longint'(1) <<< (W - 1)) - 1;
    lo = -(longint'(1) <<< (W - 1));
    for (int i = 0; i < L; i++) begin
      p = longint'($signed(a[i*W +: W])) * longint'($signed(b[i*W +: W]));
      if (m == 2) begin
        acc_m[i] = (f ? 0 : acc_m[i]) + p;
        r = acc_m[i] >>> F;
        emit = l;
      end else begin
        acc_m[i] = 0;
        r = m == 1 ? (p + (longint'(1) <<< (F - 1))) >>> F : p >>> F;
      end
      if (r > hi || r < lo) begin
        if (emit) ovf_m[i] = 1'b1;
        r = r > hi ? hi : lo;
      end
      e.data[i*W +: W] = r[W-1:0];
    end
    if (emit) begin
      if (clr_next) begin
        ovf_m = '0;
        clr_next = 0;
      end
      e.ovf = ovf_m;
      e.t = cyc;
      e.st = stalls;
      sb.push_back(e);
    end
  endtask

  task automatic send(logic [1:0] m, logic [L*W-1:0] a, logic [L*W-1:0] b, bit f, bit l);
    bit ok = 0;
    in_mode = m; in_a = a; in_b = b; in_first = f; in_last = l; in_valid = 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        model(m, a, b, f, l);
        break;
      end
      @(posedge clk); #1;
    end
    check("accept_timeout", ok, 1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
    check("drain", 64'(sb.size()), 0);
    @(posedge clk); #1;
  endtask

  function automatic logic [L*W-1:0] rv();
    logic [L*W-1:0] v;
    for (int i = 0; i < L; i++) v[i*W +: W] = W'($urandom);
    return v;
  endfunction

  function automatic logic [L*W-1:0] lane0(logic [W-1:0] x);
    logic [L*W-1:0] v;
    v = rv();
    v[W-1:0] = x;
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on each output transfer and watches stalls
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid && !out_ready) begin
        stalls++;
        saw_full = saw_full || !in_ready;
        check("in_ready_stall", in_ready, 0);
        if (holding) check("stall_hold", out_data, held);
        held = out_data;
        holding = 1;
      end else holding = 0;
      if (out_valid && out_ready) begin
        n_out++;
        last_out = out_data;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h expected none", out_data);
        end else begin
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          check("out_ovf", out_ovf, e.ovf);
          if (e.st == stalls) check("latency", 64'(cyc - e.t), 3);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < L; i++) acc_m[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1;
    @(posedge clk); #1;

    send(0, lane0(16'h00aa), lane0(16'h0092), 0, 0); drain();
    check("trunc_pos", last_out[W-1:0], 16'h00c1);
    check("trunc_pos_ovf", out_ovf[0], 0);
    send(1, lane0(16'h00aa), lane0(16'h0092), 0, 0); drain();
    check("rnd_pos", last_out[W-1:0], 16'h00c2);
    send(0, lane0(16'hfffd), lane0(16'h00a0), 0, 0); drain();
    check("trunc_neg", last_out[W-1:0], 16'hfffc);
    send(1, lane0(16'hfffd), lane0(16'h00a0), 0, 0); drain();
    check("rnd_neg", last_out[W-1:0], 16'hfffc);
    send(3, lane0(16'h0001), lane0(16'h0011), 0, 0); drain();
    check("tiny_rsvd_mode", last_out[W-1:0], 16'h0000);

    send(0, lane0(16'hf0ff), lane0(16'hf0ff), 0, 0); drain();
    check("sat_hi", last_out[W-1:0], 16'h7fff);
    check("sat_hi_ovf", out_ovf[0], 1);
    send(0, lane0(16'h00aa), lane0(16'h0092), 0, 0); drain();
    check("ovf_sticky", out_ovf[0], 1);
    ovf_clr = 1;
    @(posedge clk); #1;
    ovf_clr = 0;
    ovf_m = '0;
    check("ovf_clr", out_ovf, 0);
    send(0, lane0(16'h80a8), lane0(16'h0124), 0, 0); drain();
    check("sat_lo", last_out[W-1:0], 16'h8000);
    check("sat_lo_ovf", out_ovf[0], 1);
    send(0, lane0(16'h80a8), lane0(16'h0024), 0, 0); drain();
    check("neg_in_range", last_out[W-1:0], 16'hdc2f);

    clr_next = 1;
    send(0, lane0(16'hf0ff), lane0(16'hf0ff), 0, 0);
    @(posedge clk); #1;
    ovf_clr = 1;
    @(posedge clk); #1;
    ovf_clr = 0;
    drain();
    check("clr_priority", out_ovf, 0);

    n0 = n_out;
    send(2, {L{16'h0080}}, {L{16'h0100}}, 1, 0);
    send(2, {L{16'h0080}}, {L{16'h0100}}, 0, 0);
    send(2, {L{16'h0080}}, {L{16'h0100}}, 0, 1);
    drain();
    check("mac_one_out", 64'(n_out - n0), 1);
    check("mac_sum", last_out, {L{16'h0300}});
    send(2, {L{16'h0040}}, {L{16'h0100}}, 1, 0);
    send(2, {L{16'h0040}}, {L{16'h0100}}, 0, 1);
    drain();
    check("mac_second", last_out, {L{16'h0100}});

    n0 = n_out;
    saw_full = 0;
    fork
      for (int k = 0; k < 8; k++) send(2'($urandom_range(0, 1)), rv(), rv(), 0, 0);
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();
    check("bp_count", 64'(n_out - n0), 8);
    check("bp_full", saw_full, 1);

    done = 0;
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send(2'($urandom_range(0, 3)), rv(), rv(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        done = 1;
      end
      while (!done) begin
        @(posedge clk); #1;
        out_ready = $urandom_range(0, 3) != 0;
      end
    join
    out_ready = 1;
    drain();

    out_ready = 0;
    send(0, lane0(16'hf0ff), lane0(16'hf0ff), 0, 0);
    send(2, rv(), rv(), 1, 0);
    send(2, rv(), rv(), 0, 0);
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_stall", out_valid, 1);
    #2 rst_n = 0;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_ovf", out_ovf, 0);
    check("rst_mid_data", out_data, 0);
    sb.delete();
    for (int i = 0; i < L; i++) acc_m[i] = 0;
    ovf_m = '0;
    holding = 0;
    @(posedge clk); #1;
    rst_n = 1;
    out_ready = 1;
    @(posedge clk); #1;
    send(2, {L{16'h0100}}, {L{16'h0100}}, 1, 1);
    drain();
    check("post_rst_mac", last_out, {L{16'h0200}});

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
